// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, controller opcodes,
// buffer geometry and the pad word written into unloaded program slots.
package prog_loader_pkg;

    localparam int         DEPTH    = 16;
    localparam logic [7:0] PAD_WORD = 8'h90;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ARM     = 3'd2,
        BURST   = 3'd3,
        FLUSH   = 3'd4,
        RUN     = 3'd5
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_OUT  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    // Outputs are registered one cycle ahead, so during burst slot k the
    // buffer is read at the word for slot k+1, i.e. image index k+2.
    function automatic logic [3:0] prefetch_idx(input logic [3:0] slot);
        return slot + 4'd2;
    endfunction

endpackage

// File: rtl/prog_buffer.sv
// 16x8 program image store: one synchronous write port and one combinational
// read port that returns PAD_WORD for any slot not written in this load.
module prog_buffer
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_idx,
    input  logic [4:0] count,
    output logic [7:0] rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Image storage; stale contents are masked by count rather than cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = ({1'b0, rd_idx} < count) ? mem_r[rd_idx] : PAD_WORD;

endmodule

// File: rtl/prog_loader.sv
// Host-side loader: collects a program image over valid/ready, then bursts it
// into the 4-bit controller's program memory and releases it to run.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       mem_write,
    output logic       PC_reset,
    output logic [3:0] instr,
    output logic [3:0] portin,
    output logic [4:0] word_count,
    output logic       busy,
    output logic       done,
    output logic       trunc
);

    state_e     state_r;
    logic [3:0] burst_idx_r;
    logic       load_ready_r;
    logic       mem_write_r;
    logic       pc_reset_r;
    logic [3:0] instr_r;
    logic [3:0] portin_r;
    logic [4:0] word_count_r;
    logic       busy_r;
    logic       done_r;
    logic       trunc_r;

    logic       accept_s;
    logic [3:0] rd_idx_s;
    logic [7:0] rd_data_s;

    assign accept_s = (state_r == COLLECT) && load_valid && load_ready_r;

    // Buffer read address: slot 1 while arming, then one slot ahead of the burst.
    always_comb begin
        rd_idx_s = 4'd1;
        if (state_r == BURST) begin
            rd_idx_s = prefetch_idx(burst_idx_r);
        end else begin
            rd_idx_s = 4'd1;
        end
    end

    prog_buffer u_buf (
        .clk     (clk),
        .wr_en   (accept_s),
        .wr_idx  (word_count_r[3:0]),
        .wr_data (load_data),
        .rd_idx  (rd_idx_s),
        .count   (word_count_r),
        .rd_data (rd_data_s)
    );

    // Loader FSM with all controller-facing outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            burst_idx_r  <= 4'd0;
            load_ready_r <= 1'b0;
            mem_write_r  <= 1'b0;
            pc_reset_r   <= 1'b1;
            instr_r      <= 4'd0;
            portin_r     <= 4'd0;
            word_count_r <= 5'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            trunc_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= COLLECT;
                        word_count_r <= 5'd0;
                        trunc_r      <= 1'b0;
                        load_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        pc_reset_r   <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        if (word_count_r != 5'd16) begin
                            word_count_r <= word_count_r + 5'd1;
                        end
                        if (load_last) begin
                            state_r      <= ARM;
                            load_ready_r <= 1'b0;
                        end else if (word_count_r == 5'd15) begin
                            state_r      <= ARM;
                            load_ready_r <= 1'b0;
                            trunc_r      <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    // The controller has now seen PC_reset high, so PC is 0.
                    state_r     <= BURST;
                    burst_idx_r <= 4'd0;
                    mem_write_r <= 1'b1;
                    pc_reset_r  <= 1'b0;
                    instr_r     <= rd_data_s[7:4];
                    portin_r    <= rd_data_s[3:0];
                end
                BURST: begin
                    if (burst_idx_r == 4'd15) begin
                        state_r     <= FLUSH;
                        mem_write_r <= 1'b0;
                        pc_reset_r  <= 1'b1;
                    end else begin
                        burst_idx_r <= burst_idx_r + 4'd1;
                        instr_r     <= rd_data_s[7:4];
                        portin_r    <= rd_data_s[3:0];
                    end
                end
                FLUSH: begin
                    state_r    <= RUN;
                    pc_reset_r <= 1'b0;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
                RUN: begin
                    if (start) begin
                        state_r      <= COLLECT;
                        word_count_r <= 5'd0;
                        trunc_r      <= 1'b0;
                        load_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        pc_reset_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    load_ready_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                    pc_reset_r   <= 1'b1;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign mem_write  = mem_write_r;
    assign PC_reset   = pc_reset_r;
    assign instr      = instr_r;
    assign portin     = portin_r;
    assign word_count = word_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign trunc      = trunc_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small model of the controller's
// PC/program-memory behaviour to confirm where each image word lands.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       mem_write;
    logic       PC_reset;
    logic [3:0] instr;
    logic [3:0] portin;
    logic [4:0] word_count;
    logic       busy;
    logic       done;
    logic       trunc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] img [16];
    logic [7:0] pm  [16];
    logic [3:0] pc = 4'd0;
    logic [7:0] bq [$];
    int         bs [$];
    int         cyc = 0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .mem_write  (mem_write),
        .PC_reset   (PC_reset),
        .instr      (instr),
        .portin     (portin),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .trunc      (trunc)
    );

    always #5 clk = ~clk;

    // Controller model: PC clears on a posedge with PC_reset, counts on negedge.
    always @(posedge clk) begin
        if (PC_reset === 1'b1) pc <= 4'd0;
        else if (mem_write === 1'b1) pm[pc] <= {instr, portin};
        if (mem_write === 1'b1) begin
            bq.push_back({instr, portin});
            bs.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (PC_reset === 1'b0) pc <= pc + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        while (load_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'd0, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic load_img(input int n, input logic with_last, input int gap);
        for (int i = 0; i < n; i++) begin
            send(img[i], with_last && (i == n - 1));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_sig(input string tag, input logic want_done);
        int t = 0;
        while (((want_done ? done : mem_write) !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic set_img3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int j = 0; j < 16; j++) img[j] = 8'h90;
        img[0] = a;
        img[1] = b;
        img[2] = c;
    endtask

    task automatic check_burst(input string tag);
        chk({tag, "_len"}, bq.size(), 32'd16);
        if (bq.size() == 16) begin
            for (int k = 0; k < 16; k++)
                chk($sformatf("%s_word%0d", tag, k), {24'd0, bq[k]}, {24'd0, img[(k + 1) % 16]});
            chk({tag, "_contig"}, bs[15] - bs[0], 32'd15);
        end
        for (int j = 0; j < 16; j++)
            chk($sformatf("%s_pm%0d", tag, j), {24'd0, pm[j]}, {24'd0, img[j]});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc_reset", PC_reset, 1'b1);
        chk("rst_outputs", {mem_write, instr, portin, load_ready, busy, done, trunc}, 32'd0);
        chk("rst_word_count", word_count, 5'd0);
        reset = 1'b0;
        @(negedge clk);

        // start together with load_valid in IDLE: word must not be taken
        start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0;
        chk("idle_start_valid_wc", word_count, 5'd0);
        chk("idle_start_ready", load_ready, 1'b1);

        // Reset in the middle of a burst
        set_img3(8'h61, 8'h72, 8'h90);
        load_img(3, 1'b1, 0);
        wait_sig("mw_timeout0", 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_mem_write", mem_write, 1'b0);
        chk("midrst_pc_reset", PC_reset, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_wc", word_count, 5'd0);
        @(negedge clk);

        // Basic three-word image with exact timing
        pulse_start();
        chk("t1_collect", {PC_reset, load_ready, busy, done}, 4'b1110);
        bq.delete(); bs.delete();
        load_img(3, 1'b1, 0);
        chk("t1_arm", {load_ready, mem_write, PC_reset, busy}, 4'b0011);
        @(negedge clk);
        chk("t1_burst0", {mem_write, PC_reset}, 2'b10);
        repeat (15) @(negedge clk);
        chk("t1_burst15", {mem_write, PC_reset}, 2'b10);
        @(negedge clk);
        chk("t1_flush", {mem_write, PC_reset, busy, done}, 4'b0110);
        chk("t1_flush_hold", {instr, portin}, 8'h61);
        @(negedge clk);
        chk("t1_run", {PC_reset, done, busy}, 3'b010);
        check_burst("t1");
        chk("t1_wc", word_count, 5'd3);
        chk("t1_trunc", trunc, 1'b0);

        // Same image with gapped valid
        pulse_start();
        bq.delete(); bs.delete();
        load_img(3, 1'b1, 1);
        wait_sig("done_timeout2", 1'b1);
        check_burst("t2");
        chk("t2_wc", word_count, 5'd3);
        chk("t2_trunc", trunc, 1'b0);

        // start during burst and valid during RUN are ignored
        set_img3(8'h45, 8'h33, 8'h9F);
        pulse_start();
        bq.delete(); bs.delete();
        load_img(3, 1'b1, 0);
        wait_sig("mw_timeout3", 1'b0);
        repeat (3) @(negedge clk);
        pulse_start();
        chk("t3_busy", busy, 1'b1);
        wait_sig("done_timeout3", 1'b1);
        check_burst("t3");
        load_valid = 1'b1; load_data = 8'hAA;
        repeat (4) @(negedge clk);
        chk("t3_run_wc", word_count, 5'd3);
        chk("t3_run_state", {done, load_ready, mem_write}, 3'b100);
        load_valid = 1'b0;

        // Restart from RUN and load a full 16-word image without last
        pulse_start();
        chk("t4_restart", {PC_reset, done, trunc}, 3'b100);
        chk("t4_restart_wc", word_count, 5'd0);
        for (int j = 0; j < 16; j++) img[j] = j[7:0];
        bq.delete(); bs.delete();
        load_img(16, 1'b0, 0);
        chk("t4_trunc", trunc, 1'b1);
        chk("t4_wc", word_count, 5'd16);
        wait_sig("done_timeout4", 1'b1);
        check_burst("t4");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
